// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
// Optional feature macro: AES_MULTI_KEY_EN (per-request key size selection).
package aes_pkg;

  localparam int RND_W  = 4;
  localparam int WAIT_W = 3;

  localparam logic [RND_W-1:0] AES_NR_128 = 4'd10;
  localparam logic [RND_W-1:0] AES_NR_192 = 4'd12;
  localparam logic [RND_W-1:0] AES_NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    KS_128  = 2'd0,
    KS_192  = 2'd1,
    KS_256  = 2'd2,
    KS_RSVD = 2'd3
  } key_size_e;

  // The reserved encoding falls back to the AES-128 round count.
  function automatic logic [RND_W-1:0] nr_of(input key_size_e ks);
    case (ks)
      KS_192:  return AES_NR_192;
      KS_256:  return AES_NR_256;
      default: return AES_NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_rk_index_gen.sv
// Maps the round counter to the round-key index for the selected direction,
// and flags the final round (the one that skips mix-columns).
module aes_rk_index_gen
  import aes_pkg::*;
(
  input  logic [RND_W-1:0] round_i,
  input  logic             encrypt_i,
  input  logic [RND_W-1:0] nr_i,
  output logic [RND_W-1:0] rk_idx_o,
  output logic             last_o
);

  // Decryption walks the key schedule backwards from Nr down to 0.
  assign rk_idx_o = encrypt_i ? round_i : (nr_i - round_i);
  assign last_o   = (round_i == nr_i);

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES core: key fetch, round pulses, completion handshake.
// Optional feature macro: AES_MULTI_KEY_EN adds key_size_i and per-request Nr selection.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DP_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             encrypt_i,
`ifdef AES_MULTI_KEY_EN
  input  logic [1:0]       key_size_i,
`endif
  output logic             rk_req_o,
  output logic [RND_W-1:0] rk_idx_o,
  input  logic             rk_valid_i,
  output logic             dp_load_o,
  output logic             dp_round_en_o,
  output logic             dp_mix_bypass_o,
  output logic             dp_encrypt_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(DP_LATENCY - 1);

  ctrl_state_e       state_q;
  logic [RND_W-1:0]  round_q;
  logic [WAIT_W-1:0] wait_q;
  logic              enc_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              out_valid_q;
  logic              rk_req_q;

  logic [RND_W-1:0]  nr;
  logic [RND_W-1:0]  idx;
  logic              last;
  logic              fire;

`ifdef AES_MULTI_KEY_EN
  key_size_e ks_q;
  assign nr = nr_of(ks_q);
`else
  assign nr = AES_NR_128;
`endif

  aes_rk_index_gen u_idx (
    .round_i   (round_q),
    .encrypt_i (enc_q),
    .nr_i      (nr),
    .rk_idx_o  (idx),
    .last_o    (last)
  );

  // A round is issued in the very cycle its key arrives, so pulses are gated by rk_valid_i.
  assign fire = (state_q == ST_KEY) && rk_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      wait_q      <= '0;
      enc_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rk_req_q    <= 1'b0;
`ifdef AES_MULTI_KEY_EN
      ks_q        <= KS_128;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            enc_q      <= encrypt_i;
`ifdef AES_MULTI_KEY_EN
            ks_q       <= key_size_e'(key_size_i);
`endif
            round_q    <= '0;
            state_q    <= ST_KEY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            rk_req_q   <= 1'b1;
          end
        end
        ST_KEY: begin
          if (rk_valid_i) begin
            if (DP_LATENCY > 1) begin
              state_q  <= ST_EXEC;
              wait_q   <= WAIT_INIT;
              rk_req_q <= 1'b0;
            end else if (last) begin
              state_q     <= ST_DONE;
              rk_req_q    <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              round_q <= round_q + RND_W'(1);
            end
          end
        end
        ST_EXEC: begin
          if (wait_q == WAIT_W'(1)) begin
            if (last) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              round_q  <= round_q + RND_W'(1);
              state_q  <= ST_KEY;
              rk_req_q <= 1'b1;
            end
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign busy_o          = busy_q;
  assign out_valid_o     = out_valid_q;
  assign rk_req_o        = rk_req_q;
  assign rk_idx_o        = (state_q == ST_KEY) ? idx : '0;
  assign dp_load_o       = fire && (round_q == '0);
  assign dp_round_en_o   = fire && (round_q != '0);
  assign dp_mix_bypass_o = fire && last;
  assign dp_encrypt_o    = enc_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed-vector bench for aes_round_ctrl: one DUT at DP_LATENCY=1, one at DP_LATENCY=3.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_valid3 = 1'b0;
  logic       encrypt = 1'b1;
  logic [1:0] key_size = 2'd0;
  logic       rk_valid = 1'b1;
  logic       out_ready = 1'b1, out_ready3 = 1'b1;

  logic       in_ready1, rk_req1, dp_load1, dp_round_en1, dp_mix_bypass1, dp_encrypt1, out_valid1, busy1;
  logic [3:0] rk_idx1;
  logic       in_ready3, rk_req3, dp_load3, dp_round_en3, dp_mix_bypass3, dp_encrypt3, out_valid3, busy3;
  logic [3:0] rk_idx3;

  logic [11:0] obs1, obs3;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.DP_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1), .encrypt_i(encrypt),
`ifdef AES_MULTI_KEY_EN
    .key_size_i(key_size),
`endif
    .rk_req_o(rk_req1), .rk_idx_o(rk_idx1), .rk_valid_i(rk_valid), .dp_load_o(dp_load1),
    .dp_round_en_o(dp_round_en1), .dp_mix_bypass_o(dp_mix_bypass1), .dp_encrypt_o(dp_encrypt1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .busy_o(busy1)
  );

  aes_round_ctrl #(.DP_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid3), .in_ready_o(in_ready3), .encrypt_i(encrypt),
`ifdef AES_MULTI_KEY_EN
    .key_size_i(key_size),
`endif
    .rk_req_o(rk_req3), .rk_idx_o(rk_idx3), .rk_valid_i(rk_valid), .dp_load_o(dp_load3),
    .dp_round_en_o(dp_round_en3), .dp_mix_bypass_o(dp_mix_bypass3), .dp_encrypt_o(dp_encrypt3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3), .busy_o(busy3)
  );

  assign obs1 = {busy1, in_ready1, rk_req1, rk_idx1, dp_load1, dp_round_en1, dp_mix_bypass1, dp_encrypt1, out_valid1};
  assign obs3 = {busy3, in_ready3, rk_req3, rk_idx3, dp_load3, dp_round_en3, dp_mix_bypass3, dp_encrypt3, out_valid3};

  function automatic logic [11:0] ev(input logic busy, input logic inr, input logic req, input logic [3:0] idx,
                                     input logic ld, input logic re, input logic byp, input logic enc,
                                     input logic ov);
    return {busy, inr, req, idx, ld, re, byp, enc, ov};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs1 !== ev(0,1,0,4'd0,0,0,0,0,0)) begin
      bad++; $display("FAIL reset1 got=%h exp=%h", obs1, ev(0,1,0,4'd0,0,0,0,0,0));
    end
    total++;
    if (obs3 !== ev(0,1,0,4'd0,0,0,0,0,0)) begin
      bad++; $display("FAIL reset3 got=%h exp=%h", obs3, ev(0,1,0,4'd0,0,0,0,0,0));
    end
  endtask

  task automatic test_enc128();
    logic [11:0] e;
    encrypt = 1'b1; in_valid = 1'b1; rk_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; encrypt = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      if (t <= 11) e = ev(1,0,1,4'(t-1), t==1, t>1, t==11, 1, 0);
      else         e = ev(1,0,0,4'd0,0,0,0,1,1);
      @(negedge clk);
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL enc128 t=%0d got=%h exp=%h", t, obs1, e); end
      @(posedge clk); #1;
    end
    encrypt = 1'b1;
  endtask

  task automatic test_dec128();
    logic [11:0] e;
    encrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; encrypt = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      if (t <= 11) e = ev(1,0,1,4'(11-t), t==1, t>1, t==11, 0, 0);
      else         e = ev(1,0,0,4'd0,0,0,0,0,1);
      @(negedge clk);
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL dec128 t=%0d got=%h exp=%h", t, obs1, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [11:0] e;
    int r;
    logic v;
    encrypt = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      v = !(t >= 6 && t <= 8);
      rk_valid = v;
      r = (t <= 5) ? t - 1 : (t <= 8) ? 5 : t - 4;
      if (t <= 14) e = ev(1,0,1,4'(r), v && r==0, v && r>0, v && r==10, 1, 0);
      else         e = ev(1,0,0,4'd0,0,0,0,1,1);
      @(negedge clk);
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL stall t=%0d got=%h exp=%h", t, obs1, e); end
      @(posedge clk); #1;
    end
    rk_valid = 1'b1;
  endtask

  task automatic test_out_backpressure();
    encrypt = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 1; t <= 17; t++) begin
      if (t >= 12 && t <= 15) in_valid = 1'b1;
      if (t == 16) begin out_ready = 1'b1; in_valid = 1'b0; end
      @(negedge clk);
      if (t >= 12 && t <= 16) begin
        total++;
        if (obs1 !== ev(1,0,0,4'd0,0,0,0,1,1)) begin
          bad++; $display("FAIL backpressure t=%0d got=%h exp=%h", t, obs1, ev(1,0,0,4'd0,0,0,0,1,1));
        end
      end
      if (t == 17) begin
        total++;
        if ({busy1, in_ready1, out_valid1} !== 3'b010) begin
          bad++; $display("FAIL bp_idle got=%b exp=010", {busy1, in_ready1, out_valid1});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid();
    logic [11:0] e;
    encrypt = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      if (t == 5) rst = 1'b1;
      if (t == 6) rst = 1'b0;
      e = (t <= 5) ? ev(1,0,1,4'(t-1), t==1, t>1, 0, 1, 0) : ev(0,1,0,4'd0,0,0,0,0,0);
      @(negedge clk);
      if (t >= 5) begin
        total++;
        if (obs1 !== e) begin bad++; $display("FAIL rst_mid t=%0d got=%h exp=%h", t, obs1, e); end
      end
      @(posedge clk); #1;
    end
    encrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      e = (t == 1)  ? ev(1,0,1,4'd10,1,0,0,0,0) :
          (t == 12) ? ev(1,0,0,4'd0,0,0,0,0,1) : ev(1,0,1,4'(11-t),0,1,t==11,0,0);
      @(negedge clk);
      if (t == 1 || t >= 11) begin
        total++;
        if (obs1 !== e) begin bad++; $display("FAIL rst_recover t=%0d got=%h exp=%h", t, obs1, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exec_latency();
    logic [11:0] e;
    int nr, last_t, r;
`ifdef AES_MULTI_KEY_EN
    nr = 14; key_size = 2'd2;
`else
    nr = 10;
`endif
    last_t = 3 * (nr + 1) + 1;
    encrypt = 1'b1; in_valid3 = 1'b1; rk_valid = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0; key_size = 2'd0;
    for (int t = 1; t <= last_t; t++) begin
      r = (t - 1) / 3;
      if (t == last_t)          e = ev(1,0,0,4'd0,0,0,0,1,1);
      else if ((t - 1) % 3 == 0) e = ev(1,0,1,4'(r), r==0, r>0, r==nr, 1, 0);
      else                      e = ev(1,0,0,4'd0,0,0,0,1,0);
      @(negedge clk);
      total++;
      if (obs3 !== e) begin bad++; $display("FAIL exec t=%0d got=%h exp=%h", t, obs3, e); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if ({busy3, in_ready3, out_valid3} !== 3'b010) begin
      bad++; $display("FAIL exec_idle got=%b exp=010", {busy3, in_ready3, out_valid3});
    end
  endtask

  initial begin
    test_reset();
    test_enc128();
    test_dec128();
    test_stall();
    test_out_backpressure();
    test_rst_mid();
    test_exec_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
